// File: rtl/commit_trap_tracker_pkg.sv
// Shared types and constants for the commit/trap tracker that feeds the
// simulation Monitor.
package commit_trap_tracker_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] DEFAULT_TIMEOUT_CODE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REPORT,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/commit_lane_scan.sv
// Combinational scan of the commit lanes: first trapping lane, retire count up
// to and including it, and the PC of the youngest valid lane.
module commit_lane_scan
  import commit_trap_tracker_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int IDX_W        = 1,
  parameter int LANE_CNT_W   = 2
) (
  input  logic [COMMIT_WIDTH-1:0]       valid,
  input  logic [COMMIT_WIDTH-1:0]       trap,
  input  logic [CNT_W*COMMIT_WIDTH-1:0] pc,
  output logic                          any_valid,
  output logic                          trap_hit,
  output logic [IDX_W-1:0]              trap_idx,
  output logic [LANE_CNT_W-1:0]         count,
  output logic [CNT_W-1:0]              last_pc
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    any_valid = 1'b0;
    trap_hit  = 1'b0;
    trap_idx  = '0;
    count     = '0;
    last_pc   = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (valid[i]) begin
        any_valid = 1'b1;
        last_pc   = pc[CNT_W*i +: CNT_W];
        // Lanes younger than the trap do not retire.
        if (!trap_hit) begin
          count = count + LANE_CNT_W'(1);
          if (trap[i]) begin
            trap_hit = 1'b1;
            trap_idx = IDX_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/commit_trap_tracker.sv
// Watches the retire interface, runs cycle/instruction counters and issues a
// single registered trap report on a NOOP trap or a commit-stall timeout.
module commit_trap_tracker
  import commit_trap_tracker_pkg::*;
#(
  parameter int              COMMIT_WIDTH   = 2,
  parameter int unsigned     TIMEOUT_CYCLES = 5000,
  parameter logic [CNT_W-1:0] TIMEOUT_CODE  = DEFAULT_TIMEOUT_CODE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COMMIT_WIDTH-1:0]       io_commit_valid,
  input  logic [COMMIT_WIDTH-1:0]       io_commit_trap,
  input  logic [CNT_W*COMMIT_WIDTH-1:0] io_commit_pc,
  input  logic [CNT_W-1:0]              io_trap_code,
  output logic                          isNoopTrap,
  output logic [CNT_W-1:0]              trapCode,
  output logic [CNT_W-1:0]              trapPC,
  output logic [CNT_W-1:0]              cycleCnt,
  output logic [CNT_W-1:0]              instrCnt,
  output logic                          halted
);

  localparam int IDX_W      = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
  localparam int LANE_CNT_W = $clog2(COMMIT_WIDTH + 1);

  state_e state_q, state_d;
  logic   report_q, halted_q;

  logic [CNT_W-1:0] cycle_q, instr_q, stall_q, last_pc_q, code_q, pc_q;

  logic                  any_valid, trap_hit;
  logic [IDX_W-1:0]      trap_idx;
  logic [LANE_CNT_W-1:0] lane_count;
  logic [CNT_W-1:0]      scan_last_pc, trap_pc;
  logic                  running, timeout_hit;

  commit_lane_scan #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .IDX_W       (IDX_W),
    .LANE_CNT_W  (LANE_CNT_W)
  ) u_scan (
    .valid    (io_commit_valid),
    .trap     (io_commit_trap),
    .pc       (io_commit_pc),
    .any_valid(any_valid),
    .trap_hit (trap_hit),
    .trap_idx (trap_idx),
    .count    (lane_count),
    .last_pc  (scan_last_pc)
  );

  always_comb begin
    trap_pc = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (trap_idx == IDX_W'(i)) trap_pc = io_commit_pc[CNT_W*i +: CNT_W];
    end
  end

  assign running     = (state_q == ST_RUN);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !any_valid &&
                       (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (trap_hit || timeout_hit) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Report flags are decoded from the next state so they leave a flop directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      report_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      report_q <= (state_d == ST_REPORT);
      halted_q <= (state_d != ST_RUN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instr_q   <= '0;
      stall_q   <= '0;
      last_pc_q <= '0;
      code_q    <= '0;
      pc_q      <= '0;
    end else if (running) begin
      cycle_q <= cycle_q + 1;
      instr_q <= instr_q + CNT_W'(lane_count);
      if (any_valid) begin
        last_pc_q <= scan_last_pc;
        stall_q   <= '0;
      end else begin
        stall_q <= stall_q + 1;
      end
      // A timeout needs an idle cycle, so it can never coincide with a trap.
      if (trap_hit) begin
        code_q <= io_trap_code;
        pc_q   <= trap_pc;
      end else if (timeout_hit) begin
        code_q <= TIMEOUT_CODE;
        pc_q   <= last_pc_q;
      end
    end
  end

  assign isNoopTrap = report_q;
  assign halted     = halted_q;
  assign trapCode   = code_q;
  assign trapPC     = pc_q;
  assign cycleCnt   = cycle_q;
  assign instrCnt   = instr_q;

endmodule

// File: tb/tb_commit_trap_tracker.sv
// Self-checking bench for commit_trap_tracker: a reference model pushes each
// expected report to a scoreboard which is popped when the DUT pulses.
module tb_commit_trap_tracker;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  io_commit_valid;
  logic [1:0]  io_commit_trap;
  logic [63:0] io_commit_pc;
  logic [31:0] io_trap_code;
  logic        isNoopTrap;
  logic [31:0] trapCode, trapPC, cycleCnt, instrCnt;
  logic        halted;

  always #5 clk = ~clk;

  commit_trap_tracker #(
    .COMMIT_WIDTH  (2),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_CODE  (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_commit_valid(io_commit_valid),
    .io_commit_trap (io_commit_trap),
    .io_commit_pc   (io_commit_pc),
    .io_trap_code   (io_trap_code),
    .isNoopTrap     (isNoopTrap),
    .trapCode       (trapCode),
    .trapPC         (trapPC),
    .cycleCnt       (cycleCnt),
    .instrCnt       (instrCnt),
    .halted         (halted)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] cyc;
    logic [31:0] instr;
  } rep_t;
  rep_t sb[$];

  typedef enum {M_RUN, M_REPORT, M_HALTED} mstate_e;
  mstate_e     m_state;
  logic [31:0] m_cyc, m_instr, m_stall, m_last, m_code, m_pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_RUN;
    m_cyc = '0; m_instr = '0; m_stall = '0; m_last = '0; m_code = '0; m_pc = '0;
  endtask

  task automatic set_idle();
    io_commit_valid = '0;
    io_commit_trap  = '0;
    io_commit_pc    = '0;
    io_trap_code    = '0;
  endtask

  // Compare the registered outputs with the model state reached at the last edge.
  task automatic observe();
    rep_t r;
    check("cycleCnt", cycleCnt, m_cyc);
    check("instrCnt", instrCnt, m_instr);
    check("trapCode", trapCode, m_code);
    check("trapPC", trapPC, m_pc);
    check("halted", 32'(halted), 32'(m_state != M_RUN));
    check("isNoopTrap", 32'(isNoopTrap), 32'(m_state == M_REPORT));
    if (isNoopTrap) begin
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check("sb_code", trapCode, r.code);
        check("sb_pc", trapPC, r.pc);
        check("sb_cyc", cycleCnt, r.cyc);
        check("sb_instr", instrCnt, r.instr);
      end
    end
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model, wait.
  task automatic drive(input logic [1:0] v, input logic [1:0] t,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] code);
    int tl;
    int cnt;
    rep_t r;
    observe();
    io_commit_valid = v;
    io_commit_trap  = t;
    io_commit_pc    = {p1, p0};
    io_trap_code    = code;
    case (m_state)
      M_REPORT: m_state = M_HALTED;
      M_RUN: begin
        m_cyc = m_cyc + 32'd1;
        if (v[0] && t[0])      tl = 0;
        else if (v[1] && t[1]) tl = 1;
        else                   tl = -1;
        cnt = (tl == 0) ? int'(v[0]) : int'(v[0]) + int'(v[1]);
        m_instr = m_instr + 32'(cnt);
        if (tl >= 0) begin
          m_code  = code;
          m_pc    = (tl == 0) ? p0 : p1;
          m_state = M_REPORT;
        end else if (v == 2'b00 && m_stall == 32'(TO - 1)) begin
          m_code  = 32'hFFFF_FFFF;
          m_pc    = m_last;
          m_state = M_REPORT;
        end
        if (v != 2'b00) begin
          m_last  = v[1] ? p1 : p0;
          m_stall = '0;
        end else begin
          m_stall = m_stall + 32'd1;
        end
        if (m_state == M_REPORT) begin
          r = '{m_code, m_pc, m_cyc, m_instr};
          sb.push_back(r);
        end
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic expect_report(input string tag, input logic [31:0] code,
                               input logic [31:0] pc, input logic [31:0] cyc,
                               input logic [31:0] instr);
    check({tag, "_pulse"}, 32'(isNoopTrap), 32'd1);
    check({tag, "_code"}, trapCode, code);
    check({tag, "_pc"}, trapPC, pc);
    check({tag, "_cyc"}, cycleCnt, cyc);
    check({tag, "_instr"}, instrCnt, instr);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic do_reset();
    check("sb_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    #2;
    reset = 1'b1;
    set_idle();
    #1;
    check("rst_isNoopTrap", 32'(isNoopTrap), 32'd0);
    check("rst_trapCode", trapCode, 32'd0);
    check("rst_trapPC", trapPC, 32'd0);
    check("rst_cycleCnt", cycleCnt, 32'd0);
    check("rst_instrCnt", instrCnt, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    model_reset();
    do_reset();

    // Ten dual-lane cycles, then a lane-0 trap (lane-1 trap flag on an invalid lane).
    for (int i = 0; i < 10; i++)
      drive(2'b11, 2'b00, 32'h8000_0000 + 32'(8 * i), 32'h8000_0004 + 32'(8 * i), 32'h0);
    drive(2'b01, 2'b11, 32'h8000_0040, 32'h8000_0044, 32'h0);
    expect_report("lane0", 32'h0, 32'h8000_0040, 32'd11, 32'd21);
    idle(3);

    // Reset from HALTED; trap on lane 1 with lane 0 also retiring.
    do_reset();
    drive(2'b11, 2'b00, 32'h8000_1000, 32'h8000_1004, 32'h0);
    drive(2'b11, 2'b00, 32'h8000_1008, 32'h8000_100C, 32'h0);
    drive(2'b11, 2'b10, 32'h8000_1010, 32'h8000_1014, 32'h1);
    expect_report("lane1", 32'h1, 32'h8000_1014, 32'd3, 32'd6);
    idle(2);

    // Both lanes trapping: lane 0 wins and lane 1 is not counted.
    do_reset();
    drive(2'b11, 2'b11, 32'h8000_2000, 32'h8000_2004, 32'h5);
    expect_report("both", 32'h5, 32'h8000_2000, 32'd1, 32'd1);
    idle(2);

    // Non-contiguous commit on lane 1 only, then stall until timeout.
    do_reset();
    drive(2'b10, 2'b01, 32'h8000_00F0, 32'h8000_0100, 32'h9);
    idle(TO);
    expect_report("timeout", 32'hFFFF_FFFF, 32'h8000_0100, 32'd9, 32'd1);
    // Halted: commits and traps must be ignored.
    for (int i = 0; i < 20; i++)
      drive(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom);

    // Reset mid-RUN, then a trap in the very first cycle after reset.
    do_reset();
    drive(2'b11, 2'b00, 32'h8000_3000, 32'h8000_3004, 32'h0);
    drive(2'b01, 2'b00, 32'h8000_3008, 32'h0, 32'h0);
    drive(2'b11, 2'b00, 32'h8000_300C, 32'h8000_3010, 32'h0);
    do_reset();
    drive(2'b01, 2'b01, 32'h8000_0200, 32'h0, 32'h7);
    expect_report("post_rst", 32'h7, 32'h8000_0200, 32'd1, 32'd1);
    idle(2);

    check("sb_final", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
